// File: rtl/lib_switchblock_pkg.sv
// Shared switch-block constants: PN LFSR geometry (common with the dither
// generator) and the PN checker state encoding.
package lib_switchblock_pkg;

  localparam int PN_WIDTH = 8;
  localparam int PN_TAP_A = 7;
  localparam int PN_TAP_B = 5;
  localparam logic [PN_WIDTH-1:0] PN_SEED = 8'hFF;

  typedef enum logic [1:0] {
    FILL,
    HUNT,
    LOCKED
  } pn_chk_state_t;

endpackage

// File: rtl/pn_sequence_checker.sv
// Self-synchronising PN checker: locks onto the 8-bit LFSR stream, then flywheels and flags bit errors.
// Define PN_CHECKER_ERR_COUNT_EN to build the saturating error counter and honour clear_i.
module pn_sequence_checker
  import lib_switchblock_pkg::*;
#(
  parameter int LOCK_THRESH   = 16,
  parameter int UNLOCK_THRESH = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             pn_valid_i,
  input  logic             pn_seq_i,
  input  logic             clear_i,
  output logic             lock_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_count_o
);

  pn_chk_state_t       state_q, state_d;
  logic [PN_WIDTH-1:0] hist_q, hist_d;
  logic [2:0]          fill_cnt_q, fill_cnt_d;
  logic [7:0]          match_cnt_q, match_cnt_d;
  logic [3:0]          miss_cnt_q, miss_cnt_d;
  logic                lock_q, lock_d;
  logic                err_q, err_d;

  logic       pred;
  logic       mismatch;
  logic [7:0] match_inc;
  logic [3:0] miss_inc;

  assign pred      = hist_q[PN_TAP_A] ^ hist_q[PN_TAP_B];
  assign mismatch  = pn_seq_i ^ pred;
  assign match_inc = match_cnt_q + 8'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    lock_d      = lock_q;
    err_d       = 1'b0;

    if (pn_valid_i) begin
      unique case (state_q)
        FILL: begin
          hist_d = {hist_q[PN_WIDTH-2:0], pn_seq_i};
          if (fill_cnt_q == 3'd7) begin
            state_d     = HUNT;
            fill_cnt_d  = 3'd0;
            match_cnt_d = 8'd0;
          end else begin
            fill_cnt_d = fill_cnt_q + 3'd1;
          end
        end

        // An all-zero history predicts zero forever, so it must never count as a match.
        HUNT: begin
          hist_d = {hist_q[PN_WIDTH-2:0], pn_seq_i};
          if (!mismatch && (hist_q != '0)) begin
            match_cnt_d = match_inc;
            if (match_inc == 8'(LOCK_THRESH)) begin
              state_d    = LOCKED;
              lock_d     = 1'b1;
              miss_cnt_d = 4'd0;
            end
          end else begin
            match_cnt_d = 8'd0;
          end
        end

        // Flywheel on the prediction so a corrupted bit never pollutes later predictions.
        LOCKED: begin
          hist_d = {hist_q[PN_WIDTH-2:0], pred};
          if (mismatch) begin
            err_d      = 1'b1;
            miss_cnt_d = miss_inc;
            if (miss_inc == 4'(UNLOCK_THRESH)) begin
              state_d    = FILL;
              fill_cnt_d = 3'd0;
              lock_d     = 1'b0;
            end
          end else begin
            miss_cnt_d = 4'd0;
          end
        end

        default: begin
          state_d    = FILL;
          fill_cnt_d = 3'd0;
          lock_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= FILL;
      hist_q      <= '0;
      fill_cnt_q  <= 3'd0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 4'd0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
    end
  end

  assign lock_o = lock_q;
  assign err_o  = err_q;

`ifdef PN_CHECKER_ERR_COUNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Clear takes priority over a coincident error.
  always_comb begin
    err_count_d = err_count_q;
    if (clear_i) begin
      err_count_d = '0;
    end else if (err_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count_o = err_count_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign err_count_o  = '0;
`endif

endmodule
